generator_sched: RTL and testbench

- Round-robin scheduler that shares one `generator` counter instance between NREQ requesters.
- Each requester asks for a burst of LEN consecutive count values, optionally with a generator clear first.
- The block drives the generator's `res`/`en` inputs and returns the sampled counts to the granted requester, tagged with its id.
- Sits between game-logic clients (level fill, enemy spawn) and the shared generator.

---
 rtl/dash_pkg.sv | 18 +
 rtl/rr_pick.sv | 40 ++++
 rtl/generator_sched.sv | 206 ++++++++++++++++++++
 tb/tb_generator_sched.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dash_pkg.sv
// Shared definitions for the generator scheduler slice.
//   state_t      : scheduler FSM encoding
//   *_DEF        : default sizing used by the scheduler and its picker
package dash_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NREQ_DEF  = 4;
  localparam int LEN_W_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int ID_W_DEF  = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at index ptr, moving upward and wrapping modulo NREQ,
// and reports the first set bit.
//   req : request vector
//   ptr : highest-priority index for this search
//   win : one-hot winner (all zero when req is empty)
//   id  : binary index of the winner (zero when req is empty)
module rr_pick
  import dash_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int ID_W = ID_W_DEF
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] win,
  output logic [ID_W-1:0] id
);

  logic found_s;

  // Rotating priority search: k is the distance from ptr, i the candidate index.
  always_comb begin
    win     = {NREQ{1'b0}};
    id      = {ID_W{1'b0}};
    found_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found_s && req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
          found_s = 1'b1;
          win[i]  = 1'b1;
          id      = ID_W'(i);
        end else begin
          found_s = found_s;
        end
      end
    end
  end

endmodule

// File: rtl/generator_sched.sv
// Round-robin scheduler sharing one generator counter between NREQ requesters.
// A granted requester gets a burst of LEN consecutive count values, optionally
// preceded by a one-cycle generator clear. Every output is registered.
//   clk, res_n : clock, asynchronous active-low reset
//   req        : per-requester request level (held until own gnt)
//   req_len    : per-requester burst length, slice i at [i*LEN_W +: LEN_W], 0 = 2^LEN_W
//   req_clr    : per-requester "clear generator first" flag
//   gnt        : one-hot grant, held for the whole burst
//   busy       : high whenever the scheduler is not idle
//   gen_res    : generator synchronous clear
//   gen_en     : generator count enable
//   gen_count  : generator count value
//   out_valid, out_data, out_id, out_last : burst data stream to the owner
//   done       : one-cycle completion pulse to the finished requester
module generator_sched
  import dash_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic [NREQ-1:0]       req_clr,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  gen_res,
  output logic                  gen_en,
  input  logic [CNT_W-1:0]      gen_count,
  output logic                  out_valid,
  output logic [CNT_W-1:0]      out_data,
  output logic [ID_W-1:0]       out_id,
  output logic                  out_last,
  output logic [NREQ-1:0]       done
);

  state_t            state_r, state_s;
  logic [NREQ-1:0]   gnt_r, gnt_s;
  logic [NREQ-1:0]   done_r, done_s;
  logic              busy_r, busy_s;
  logic              gen_res_r, gen_res_s;
  logic              gen_en_r, gen_en_s;
  logic              out_valid_r, out_valid_s;
  logic [CNT_W-1:0]  out_data_r, out_data_s;
  logic [ID_W-1:0]   out_id_r, out_id_s;
  logic              out_last_r, out_last_s;
  // One extra bit so a zero length field can stand for 2^LEN_W words.
  logic [LEN_W:0]    rem_r, rem_s;
  logic [ID_W-1:0]   win_r, win_s;
  logic [ID_W-1:0]   ptr_r, ptr_s;

  logic [NREQ-1:0]   pick_win_s;
  logic [ID_W-1:0]   pick_id_s;
  logic [LEN_W-1:0]  sel_len_s;
  logic              sel_clr_s;
  logic [LEN_W:0]    len_ext_s;

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req (req),
    .ptr (ptr_r),
    .win (pick_win_s),
    .id  (pick_id_s)
  );

  // Select the winning requester's length and clear flag; expand length 0 to 2^LEN_W.
  always_comb begin
    sel_len_s = {LEN_W{1'b0}};
    sel_clr_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_win_s[i]) begin
        sel_len_s = req_len[i*LEN_W +: LEN_W];
        sel_clr_s = req_clr[i];
      end else begin
        sel_clr_s = sel_clr_s;
      end
    end
    if (sel_len_s == {LEN_W{1'b0}}) begin
      len_ext_s = {1'b1, {LEN_W{1'b0}}};
    end else begin
      len_ext_s = {1'b0, sel_len_s};
    end
  end

  // Next-state and next-output logic; pulses default low, held values default to current.
  always_comb begin
    state_s     = state_r;
    gnt_s       = gnt_r;
    done_s      = {NREQ{1'b0}};
    gen_res_s   = 1'b0;
    gen_en_s    = 1'b0;
    out_valid_s = 1'b0;
    out_last_s  = 1'b0;
    out_data_s  = out_data_r;
    out_id_s    = out_id_r;
    rem_s       = rem_r;
    win_s       = win_r;
    ptr_s       = ptr_r;

    case (state_r)
      IDLE: begin
        if (|req) begin
          win_s = pick_id_s;
          gnt_s = pick_win_s;
          rem_s = len_ext_s;
          if (sel_clr_s) begin
            state_s   = CLEAR;
            gen_res_s = 1'b1;
          end else begin
            state_s  = RUN;
            gen_en_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end

      CLEAR: begin
        state_s  = RUN;
        gen_en_s = 1'b1;
      end

      RUN: begin
        // gen_count is still the pre-increment value at this edge.
        out_valid_s = 1'b1;
        out_data_s  = gen_count;
        out_id_s    = win_r;
        rem_s       = rem_r - {{LEN_W{1'b0}}, 1'b1};
        if (rem_r == {{LEN_W{1'b0}}, 1'b1}) begin
          out_last_s = 1'b1;
          state_s    = DONE;
        end else begin
          gen_en_s = 1'b1;
        end
      end

      DONE: begin
        state_s = IDLE;
        done_s  = gnt_r;
        gnt_s   = {NREQ{1'b0}};
        if (win_r == ID_W'(NREQ - 1)) begin
          ptr_s = {ID_W{1'b0}};
        end else begin
          ptr_s = win_r + ID_W'(1'b1);
        end
      end

      default: begin
        state_s = IDLE;
        gnt_s   = {NREQ{1'b0}};
        rem_s   = {(LEN_W+1){1'b0}};
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State and registered outputs; reset returns everything to zero and idle.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_r     <= IDLE;
      gnt_r       <= {NREQ{1'b0}};
      done_r      <= {NREQ{1'b0}};
      busy_r      <= 1'b0;
      gen_res_r   <= 1'b0;
      gen_en_r    <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {CNT_W{1'b0}};
      out_id_r    <= {ID_W{1'b0}};
      out_last_r  <= 1'b0;
      rem_r       <= {(LEN_W+1){1'b0}};
      win_r       <= {ID_W{1'b0}};
      ptr_r       <= {ID_W{1'b0}};
    end else begin
      state_r     <= state_s;
      gnt_r       <= gnt_s;
      done_r      <= done_s;
      busy_r      <= busy_s;
      gen_res_r   <= gen_res_s;
      gen_en_r    <= gen_en_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
      out_id_r    <= out_id_s;
      out_last_r  <= out_last_s;
      rem_r       <= rem_s;
      win_r       <= win_s;
      ptr_r       <= ptr_s;
    end
  end

  assign gnt       = gnt_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign gen_res   = gen_res_r;
  assign gen_en    = gen_en_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_id    = out_id_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_generator_sched.sv
// Bench for generator_sched: a behavioural generator, a burst-level
// round-robin model feeding scoreboard queues, and a negedge monitor.
module tb_generator_sched;

  localparam int NREQ  = 4;
  localparam int LEN_W = 4;
  localparam int CNT_W = 8;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  res_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*LEN_W-1:0] req_len = '0;
  logic [NREQ-1:0]       req_clr = '0;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  gen_res;
  logic                  gen_en;
  logic [CNT_W-1:0]      gen_count = '0;
  logic                  out_valid;
  logic [CNT_W-1:0]      out_data;
  logic [ID_W-1:0]       out_id;
  logic                  out_last;
  logic [NREQ-1:0]       done;

  generator_sched #(
    .NREQ (NREQ), .LEN_W (LEN_W), .CNT_W (CNT_W), .ID_W (ID_W)
  ) dut (
    .clk       (clk),
    .res_n     (res_n),
    .req       (req),
    .req_len   (req_len),
    .req_clr   (req_clr),
    .gnt       (gnt),
    .busy      (busy),
    .gen_res   (gen_res),
    .gen_en    (gen_en),
    .gen_count (gen_count),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Shared generator: synchronous clear has priority over increment, wraps at 2^CNT_W.
  always @(posedge clk) begin
    if (gen_res) gen_count <= '0;
    else if (gen_en) gen_count <= gen_count + 8'd1;
  end

  typedef struct {
    int data;
    int id;
    int last;
    int gap;   // required idle negedges before this word, -1 = unchecked
  } word_t;

  word_t exp_q[$];
  int    done_q[$];

  int checks = 0;
  int errors = 0;
  int nwords = 0;
  int idle_cnt = 0;
  int cnt_res = 0;
  int cnt_en = 0;

  // Model state: generator value and round-robin pointer.
  int m_gen = 0;
  int m_ptr = 0;

  // Phase description: bursts wanted, length field and clear flag per requester.
  int ph_nb  [NREQ];
  int ph_len [NREQ];
  int ph_clr [NREQ];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},       int'(gnt), 0);
    check({tag, "_done"},      int'(done), 0);
    check({tag, "_busy"},      int'(busy), 0);
    check({tag, "_gen_res"},   int'(gen_res), 0);
    check({tag, "_gen_en"},    int'(gen_en), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"},  int'(out_data), 0);
    check({tag, "_out_id"},    int'(out_id), 0);
    check({tag, "_out_last"},  int'(out_last), 0);
  endtask

  task automatic clear_ph();
    for (int i = 0; i < NREQ; i++) begin
      ph_nb[i] = 0; ph_len[i] = 0; ph_clr[i] = 0;
    end
  endtask

  // Monitor: compares every presented word and done pulse against the queues.
  initial begin
    word_t w;
    int d;
    forever begin
      @(negedge clk);
      if (res_n) begin
        if (gen_res) cnt_res++;
        if (gen_en) cnt_en++;
        check("gnt_onehot0", int'($onehot0(gnt)), 1);
        check("res_en_excl", int'(gen_res && gen_en), 0);
        if (out_valid) begin
          check("busy_with_valid", int'(busy), 1);
          if (exp_q.size() == 0) begin
            check("unexpected_word", int'(out_data), -1);
          end else begin
            w = exp_q.pop_front();
            check("out_data", int'(out_data), w.data);
            check("out_id",   int'(out_id), w.id);
            check("out_last", int'(out_last), w.last);
            if (w.gap >= 0) check("word_gap", idle_cnt, w.gap);
          end
          idle_cnt = 0;
          nwords++;
        end else begin
          idle_cnt++;
        end
        if (done != '0) begin
          if (done_q.size() == 0) begin
            check("unexpected_done", int'(done), 0);
          end else begin
            d = done_q.pop_front();
            check("done", int'(done), 1 << d);
          end
        end
      end
    end
  end

  // Model the whole phase at burst level, then drive requests until it drains.
  task automatic do_phase(input string tag);
    int rem [NREQ];
    int drv [NREQ];
    int w, len, words, clrs, r0, e0, budget;
    bit first;
    logic [NREQ-1:0] pg;

    words = 0; clrs = 0; first = 1'b1;
    for (int i = 0; i < NREQ; i++) rem[i] = ph_nb[i];
    while (1) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (w < 0 && rem[idx] > 0) w = idx;
      end
      if (w < 0) break;
      len = (ph_len[w] == 0) ? 16 : ph_len[w];
      if (ph_clr[w] != 0) begin
        m_gen = 0;
        clrs++;
      end
      for (int j = 0; j < len; j++) begin
        word_t x;
        x.data = m_gen;
        x.id   = w;
        x.last = (j == len - 1) ? 1 : 0;
        x.gap  = (j != 0) ? 0 : (first ? -1 : 2 + ph_clr[w]);
        exp_q.push_back(x);
        m_gen = (m_gen + 1) % 256;
        words++;
      end
      done_q.push_back(w);
      rem[w]--;
      m_ptr = (w + 1) % NREQ;
      first = 1'b0;
    end

    @(negedge clk);
    r0 = cnt_res; e0 = cnt_en;
    for (int i = 0; i < NREQ; i++) begin
      drv[i] = ph_nb[i];
      if (drv[i] > 0) begin
        req_len[i*LEN_W +: LEN_W] = LEN_W'(ph_len[i]);
        req_clr[i] = 1'(ph_clr[i]);
      end else begin
        req_len[i*LEN_W +: LEN_W] = LEN_W'($urandom_range(0, 15));
        req_clr[i] = 1'($urandom_range(0, 1));
      end
      req[i] = (drv[i] > 0);
    end
    pg = '0;
    budget = 0;
    while ((exp_q.size() > 0 || done_q.size() > 0 || busy || req != '0) && budget < 3000) begin
      @(negedge clk);
      budget++;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && !pg[i]) begin
          drv[i]--;
          // Once granted, this requester's fields must no longer matter.
          if (drv[i] == 0) begin
            req_len[i*LEN_W +: LEN_W] = LEN_W'($urandom_range(0, 15));
            req_clr[i] = 1'($urandom_range(0, 1));
          end
        end
        req[i] = (drv[i] > 0);
      end
      pg = gnt;
    end
    check({tag, "_timeout"}, int'(budget >= 3000), 0);
    check({tag, "_gen_en_cycles"}, cnt_en - e0, words);
    check({tag, "_gen_res_cycles"}, cnt_res - r0, clrs);
    @(negedge clk);
  endtask

  initial begin
    int start, budget;

    // Reset state
    repeat (3) @(negedge clk);
    check_zero("reset");
    res_n = 1'b1;
    @(negedge clk);

    // Single clear burst: 0,1,2 from requester 0
    clear_ph(); ph_nb[0] = 1; ph_len[0] = 3; ph_clr[0] = 1;
    do_phase("first_clr");
    // Continue without clear: 3,4
    clear_ph(); ph_nb[0] = 1; ph_len[0] = 2; ph_clr[0] = 0;
    do_phase("no_clr");
    // Bring pointer back to 0
    clear_ph(); ph_nb[3] = 1; ph_len[3] = 1;
    do_phase("ptr_align");
    // All four held, len=1: order 0,1,2,3,0
    clear_ph();
    for (int i = 0; i < NREQ; i++) begin ph_nb[i] = 1; ph_len[i] = 1; end
    ph_nb[0] = 2;
    do_phase("rr_all");
    // Full-length burst with clear: 0..15
    clear_ph(); ph_nb[0] = 1; ph_len[0] = 0; ph_clr[0] = 1;
    do_phase("len16");
    // Walk the generator up to 254, then cross the wrap
    clear_ph(); ph_nb[1] = 14; ph_len[1] = 0;
    do_phase("preset_a");
    clear_ph(); ph_nb[2] = 1; ph_len[2] = 14;
    do_phase("preset_b");
    clear_ph(); ph_nb[3] = 1; ph_len[3] = 4;
    do_phase("wrap");

    // Randomized contention
    for (int p = 0; p < 15; p++) begin
      clear_ph();
      for (int i = 0; i < NREQ; i++) begin
        ph_nb[i]  = $urandom_range(0, 2);
        ph_len[i] = $urandom_range(0, 15);
        ph_clr[i] = $urandom_range(0, 1);
      end
      do_phase("random");
    end

    // Leave the pointer at 2, then reset in the middle of requester 2's burst
    clear_ph(); ph_nb[1] = 1; ph_len[1] = 1;
    do_phase("pre_reset");
    for (int j = 0; j < 8; j++) begin
      word_t x;
      x.data = j; x.id = 2; x.last = (j == 7) ? 1 : 0; x.gap = -1;
      exp_q.push_back(x);
    end
    @(negedge clk);
    req_len[2*LEN_W +: LEN_W] = 4'd8;
    req_clr[2] = 1'b1;
    req[2] = 1'b1;
    start = nwords;
    budget = 0;
    while (nwords < start + 3 && budget < 200) begin
      @(negedge clk);
      budget++;
      if (gnt[2]) req[2] = 1'b0;
    end
    check("mid_reset_timeout", int'(budget >= 200), 0);
    @(posedge clk);
    #2;
    res_n = 1'b0;
    #1;
    check_zero("mid_reset");
    exp_q.delete();
    done_q.delete();
    m_ptr = 0;
    repeat (2) @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);
    check("no_done_after_reset", int'(done), 0);

    // After reset requester 0 must win over requester 3
    clear_ph();
    ph_nb[0] = 1; ph_len[0] = 3; ph_clr[0] = 1;
    ph_nb[3] = 1; ph_len[3] = 2; ph_clr[3] = 0;
    do_phase("post_reset");

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size() + done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
